// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two single-slot requesters share one write port,
// plus a pending-destination scoreboard for decode hazard queries.
module rf_wb_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [4:0]  rf_A3,
    output logic [31:0] rf_WD,
    output logic        rf_RFWr,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        q_busy1,
    output logic        q_busy2
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
    } hold_t;

    hold_t       hold0;
    hold_t       hold1;
    logic        last_grant;
    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic        gnt0;
    logic        gnt1;
    logic        gnt_any;
    logic [4:0]  win_addr;
    logic [31:0] win_data;
    logic        both;

    assign req0_ready = !hold0.valid;
    assign req1_ready = !hold1.valid;
    assign both       = hold0.valid && hold1.valid;
    assign gnt_any    = gnt0 || gnt1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (1'b1)
            both: begin
                if (RR_EN != 0) begin
                    gnt0 = last_grant;
                    gnt1 = !last_grant;
                end else begin
                    gnt0 = 1'b1;
                end
            end
            hold0.valid && !hold1.valid: gnt0 = 1'b1;
            !hold0.valid && hold1.valid: gnt1 = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        win_addr = hold0.addr;
        win_data = hold0.data;
        if (gnt1) begin
            win_addr = hold1.addr;
            win_data = hold1.data;
        end
    end

    // Ready is low while a hold is full, so a drain and a refill never share an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 <= '0;
        end else if (gnt0) begin
            hold0.valid <= 1'b0;
        end else if (req0_valid && req0_ready) begin
            hold0 <= {1'b1, req0_addr, req0_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold1 <= '0;
        end else if (gnt1) begin
            hold1.valid <= 1'b0;
        end else if (req1_valid && req1_ready) begin
            hold1 <= {1'b1, req1_addr, req1_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (gnt0) begin
            last_grant <= 1'b0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
        end
    end

    // Writes to x0 are consumed but never pulse the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_RFWr <= 1'b0;
            rf_A3   <= '0;
            rf_WD   <= '0;
        end else if (gnt_any) begin
            rf_RFWr <= (win_addr != 5'd0);
            rf_A3   <= win_addr;
            rf_WD   <= win_data;
        end else begin
            rf_RFWr <= 1'b0;
        end
    end

    // Clear first, then set, so a same-edge issue keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (gnt_any && win_addr != 5'd0) begin
            busy_nxt[win_addr] = 1'b0;
        end
        if (issue_valid && issue_addr != 5'd0) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign q_busy1 = (q_a1 != 5'd0) && busy[q_a1];
    assign q_busy2 = (q_a2 != 5'd0) && busy[q_a2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: fixed-priority and round-robin instances driven together,
// checked each cycle against a behavioural model plus directed literal cases.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [31:0] req0_data = '0;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [31:0] req1_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [4:0]  q_a1 = '0;
    logic [4:0]  q_a2 = '0;

    // index 0 = fixed priority instance, index 1 = round robin instance
    logic [1:0]        rdy0, rdy1, we, qb1, qb2;
    logic [1:0][4:0]   a3;
    logic [1:0][31:0]  wd;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.RR_EN(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0[0]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1[0]),
        .rf_A3(a3[0]), .rf_WD(wd[0]), .rf_RFWr(we[0]),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(qb1[0]), .q_busy2(qb2[0])
    );

    rf_wb_arbiter #(.RR_EN(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0[1]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1[1]),
        .rf_A3(a3[1]), .rf_WD(wd[1]), .rf_RFWr(we[1]),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(qb1[1]), .q_busy2(qb2[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: per mode, a one-entry pending slot per requester,
    // the last winner, a busy set and the write-port output.
    bit          mv[2][2];
    logic [4:0]  ma[2][2];
    logic [31:0] md[2][2];
    int          mlast[2];
    logic [31:0] mbusy[2];
    bit          mwe[2];
    logic [4:0]  moa[2];
    logic [31:0] mod[2];

    function automatic int pick(int m, bit v0, bit v1, int last);
        if (v0 && v1) return (m == 1) ? 1 - last : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mv[m][0] = 0; mv[m][1] = 0; mlast[m] = 1;
                mbusy[m] = '0; mwe[m] = 0; moa[m] = '0; mod[m] = '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                automatic bit acc0 = req0_valid && !mv[m][0];
                automatic bit acc1 = req1_valid && !mv[m][1];
                automatic int g = pick(m, mv[m][0], mv[m][1], mlast[m]);
                mwe[m] = 0;
                if (g >= 0) begin
                    mwe[m] = (ma[m][g] != 0);
                    moa[m] = ma[m][g];
                    mod[m] = md[m][g];
                    mlast[m] = g;
                    mv[m][g] = 0;
                    if (ma[m][g] != 0) mbusy[m] = mbusy[m] & ~(32'd1 << ma[m][g]);
                end
                if (acc0) begin mv[m][0] = 1; ma[m][0] = req0_addr; md[m][0] = req0_data; end
                if (acc1) begin mv[m][1] = 1; ma[m][1] = req1_addr; md[m][1] = req1_data; end
                if (issue_valid && issue_addr != 0) mbusy[m] = mbusy[m] | (32'd1 << issue_addr);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("m%0d_ready0", m), rdy0[m], !mv[m][0]);
                chk($sformatf("m%0d_ready1", m), rdy1[m], !mv[m][1]);
                chk($sformatf("m%0d_rfwr", m), we[m], mwe[m]);
                if (mwe[m]) begin
                    chk($sformatf("m%0d_a3", m), a3[m], moa[m]);
                    chk($sformatf("m%0d_wd", m), wd[m], mod[m]);
                end
                chk($sformatf("m%0d_qbusy1", m), qb1[m], (q_a1 != 0) && mbusy[m][q_a1]);
                chk($sformatf("m%0d_qbusy2", m), qb2[m], (q_a2 != 0) && mbusy[m][q_a2]);
            end
        end
    end

    task automatic idle();
        req0_valid = 0; req1_valid = 0; issue_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        repeat (2) @(posedge clk);
        do_reset();
        chk_en = 1;
        #2;
        chk("rst_ready0", rdy0[1], 1);
        chk("rst_ready1", rdy1[1], 1);
        chk("rst_qbusy1", qb1[1], 0);
        chk("rst_rfwr", we[1], 0);

        // single write
        req0_valid = 1; req0_addr = 5; req0_data = 32'h12345678;
        @(negedge clk); idle(); #2;
        chk("single_ready_low", rdy0[1], 0);
        @(negedge clk); #2;
        chk("single_rfwr", we[1], 1);
        chk("single_a3", a3[1], 5);
        chk("single_wd", wd[1], 32'h12345678);
        chk("single_ready_back", rdy0[1], 1);

        // round robin conflicts
        do_reset();
        req0_valid = 1; req0_addr = 3; req0_data = 32'hA3;
        req1_valid = 1; req1_addr = 7; req1_data = 32'hB7;
        @(negedge clk); idle();
        @(negedge clk); #2;
        chk("rr1_first_a3", a3[1], 3);
        chk("rr1_first_wd", wd[1], 32'hA3);
        @(negedge clk); #2;
        chk("rr1_second_a3", a3[1], 7);
        chk("rr1_second_wd", wd[1], 32'hB7);
        req0_valid = 1; req0_addr = 1; req0_data = 32'h11;
        @(negedge clk); idle();
        @(negedge clk); #2;
        chk("rr_single_a3", a3[1], 1);
        req0_valid = 1; req0_addr = 3; req0_data = 32'hA3;
        req1_valid = 1; req1_addr = 7; req1_data = 32'hB7;
        @(negedge clk); idle();
        @(negedge clk); #2;
        chk("rr2_first_a3", a3[1], 7);
        @(negedge clk); #2;
        chk("rr2_second_a3", a3[1], 3);

        // fixed priority with requester 0 streaming
        do_reset();
        req0_valid = 1; req0_addr = 11; req0_data = 32'h100;
        req1_valid = 1; req1_addr = 10; req1_data = 32'hB10;
        @(negedge clk); req1_valid = 0; req0_data = 32'h101;
        @(negedge clk); #2;
        chk("fp_first_a3", a3[0], 11);
        chk("fp_first_wd", wd[0], 32'h100);
        req0_data = 32'h102;
        @(negedge clk); #2;
        chk("fp_req1_a3", a3[0], 10);
        chk("fp_req1_wd", wd[0], 32'hB10);
        for (int i = 3; i < 9; i++) begin
            req0_data = 32'h100 + i;
            @(negedge clk);
        end
        idle();
        repeat (2) @(negedge clk);

        // scoreboard set, clear and same-edge set/clear
        do_reset();
        issue_valid = 1; issue_addr = 9; q_a1 = 9;
        @(negedge clk); issue_valid = 0; #2;
        chk("sb_set", qb1[1], 1);
        req0_valid = 1; req0_addr = 9; req0_data = 32'h99;
        @(negedge clk); idle();
        @(negedge clk); #2;
        chk("sb_grant_rfwr", we[1], 1);
        chk("sb_clear", qb1[1], 0);
        issue_valid = 1; issue_addr = 9;
        req0_valid = 1; req0_addr = 9; req0_data = 32'h98;
        @(negedge clk); req0_valid = 0;
        @(negedge clk); issue_valid = 0; #2;
        chk("sb_both_rfwr", we[1], 1);
        chk("sb_set_wins", qb1[1], 1);

        // address zero
        do_reset();
        issue_valid = 1; issue_addr = 4; q_a2 = 4;
        @(negedge clk);
        issue_addr = 0; q_a1 = 0;
        req1_valid = 1; req1_addr = 0; req1_data = 32'hDEAD;
        @(negedge clk); idle(); #2;
        chk("x0_ready_low", rdy1[1], 0);
        chk("x0_issue_qbusy", qb1[1], 0);
        @(negedge clk); #2;
        chk("x0_ready_back", rdy1[1], 1);
        chk("x0_rfwr_rr", we[1], 0);
        chk("x0_rfwr_fp", we[0], 0);
        chk("x0_busy_kept", qb2[1], 1);

        // asynchronous reset mid-flight
        do_reset();
        issue_valid = 1; issue_addr = 4; q_a1 = 4;
        req0_valid = 1; req0_addr = 4; req0_data = 32'h44;
        req1_valid = 1; req1_addr = 6; req1_data = 32'h66;
        @(negedge clk); idle();
        @(posedge clk); #2;
        chk("ar_pre_rfwr", we[1], 1);
        chk("ar_pre_busy", qb1[1], 0);
        #1; rst_n = 0; #1;
        chk("ar_rfwr_rr", we[1], 0);
        chk("ar_rfwr_fp", we[0], 0);
        chk("ar_ready0", rdy0[1], 1);
        chk("ar_ready1", rdy1[1], 1);
        chk("ar_ready1_fp", rdy1[0], 1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            chk("ar_post_rfwr_rr", we[1], 0);
            chk("ar_post_rfwr_fp", we[0], 0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            req0_valid = ($urandom % 10) < 6;
            req0_addr = 5'($urandom);
            req0_data = $urandom;
            req1_valid = ($urandom % 10) < 6;
            req1_addr = 5'($urandom);
            req1_data = $urandom;
            issue_valid = ($urandom % 2) == 0;
            issue_addr = 5'($urandom);
            q_a1 = 5'($urandom);
            q_a2 = 5'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #3; rst_n = 0; #1; rst_n = 1;
            end
        end
        idle();
        repeat (3) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
